// File: rtl/qif_sweep_scheduler_if.sv
// Spike event channel from the QIF sweep scheduler to the spike router.
// Valid/ready handshake carrying the index of the spiking neuron.
interface qif_sweep_scheduler_if #(
  parameter int ID_W = 3
) ();
  logic            spike_valid;
  logic [ID_W-1:0] spike_id;
  logic            spike_ready;

  modport master (
    output spike_valid,
    output spike_id,
    input  spike_ready
  );

  modport slave (
    input  spike_valid,
    input  spike_id,
    output spike_ready
  );
endinterface

// File: rtl/qif_sweep_scheduler.sv
// QIF membrane sweep: one shared update datapath walks all neurons per tick
// and emits id-tagged spike events over a valid/ready channel.
module qif_sweep_scheduler #(
  parameter int               NUM_NEURONS = 8,
  parameter int               ID_W        = 3,
  parameter logic signed [7:0] VPEAK      = 8'sd50,
  parameter logic signed [7:0] VRESET     = -8'sd20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick_start,
  input  logic                   cfg_we,
  input  logic [ID_W-1:0]        cfg_addr,
  input  logic signed [7:0]      cfg_b,
  input  logic [ID_W-1:0]        mon_addr,
  output logic signed [7:0]      mon_v,
  output logic                   busy,
  output logic                   sweep_done,
  output logic                   overrun,
  qif_sweep_scheduler_if.master  spk
);

  typedef enum logic [2:0] {
    IDLE, READ, CALC, WRITE, EMIT, DONE
  } state_t;

  localparam logic [ID_W-1:0] LAST = ID_W'(NUM_NEURONS - 1);

  state_t state_q, state_d;
  logic [ID_W-1:0] idx_q, idx_d;

  logic signed [7:0] v_mem [NUM_NEURONS];
  logic signed [7:0] b_mem [NUM_NEURONS];

  logic signed [7:0] op_v, op_b;
  logic signed [7:0] nv_q, nv_d;
  logic              spk_q;
  logic              overrun_q;

  logic signed [15:0] v_ext, b_ext;
  logic signed [15:0] v3, b2, sum;

  assign busy            = (state_q != IDLE);
  assign sweep_done      = (state_q == DONE);
  assign overrun         = overrun_q;
  assign spk.spike_valid = (state_q == EMIT);
  assign spk.spike_id    = (state_q == EMIT) ? idx_q : '0;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (tick_start) begin
          state_d = READ;
          idx_d   = '0;
        end
      end
      READ:  state_d = CALC;
      CALC:  state_d = WRITE;
      WRITE: begin
        if (spk_q) begin
          state_d = EMIT;
        end else if (idx_q == LAST) begin
          state_d = DONE;
        end else begin
          state_d = READ;
          idx_d   = idx_q + ID_W'(1);
        end
      end
      EMIT: begin
        // Hold the event until the router takes it; nothing else moves.
        if (spk.spike_ready) begin
          if (idx_q == LAST) begin
            state_d = DONE;
          end else begin
            state_d = READ;
            idx_d   = idx_q + ID_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // 16-bit signed intermediates: |V/8|^2 * |B/4| peaks at 8192.
  always_comb begin
    v_ext = {{8{op_v[7]}}, op_v};
    b_ext = {{8{op_b[7]}}, op_b};
    v3    = v_ext >>> 3;
    b2    = b_ext >>> 2;
    sum   = v_ext + v3 * v3 * b2;
    if (op_v >= VPEAK) begin
      nv_d = VRESET;
    end else if (sum > 16'sd127) begin
      nv_d = 8'sd127;
    end else if (sum < -16'sd128) begin
      nv_d = -8'sd128;
    end else begin
      nv_d = sum[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      op_v  <= '0;
      op_b  <= '0;
      nv_q  <= '0;
      spk_q <= 1'b0;
    end else begin
      if (state_q == READ) begin
        op_v <= v_mem[idx_q];
        op_b <= b_mem[idx_q];
      end
      if (state_q == CALC) begin
        nv_q  <= nv_d;
        spk_q <= (op_v >= VPEAK);
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        v_mem[i] <= VRESET;
      end
    end else if (state_q == WRITE) begin
      v_mem[idx_q] <= nv_q;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        b_mem[i] <= '0;
      end
    end else if (cfg_we) begin
      b_mem[cfg_addr] <= cfg_b;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      mon_v     <= '0;
      overrun_q <= 1'b0;
    end else begin
      mon_v     <= v_mem[mon_addr];
      overrun_q <= tick_start && busy;
    end
  end

endmodule

// File: doc/qif_sweep_scheduler.md
Name: qif_sweep_scheduler

Overview:
- Time-multiplexes one QIF membrane-update datapath across NUM_NEURONS neurons.
- Neuron state V and drive B live in internal register files.
- A tick_start pulse triggers one sweep that updates every neuron in index order.
- Spikes leave as id-tagged events over a valid/ready handshake to the downstream spike router.
- Sits between the tick generator/host config bus and the spike fabric.

Parameters:
NUM_NEURONS, 8, neurons per sweep (2..64)
ID_W, 3, index width, equals ceil(log2(NUM_NEURONS))
VPEAK, 50, signed 8-bit spike threshold
VRESET, -20, signed 8-bit reset/post-spike potential

Ports:
clk  in  1  clock
rst_n  in  1  async reset, active-high despite name
tick_start  in  1  one-cycle pulse, start a sweep
cfg_we  in  1  write B for neuron cfg_addr
cfg_addr  in  ID_W  config neuron index
cfg_b  in  8  signed drive B
mon_addr  in  ID_W  monitor neuron index
mon_v  out  8  registered V[mon_addr], 1-cycle latency
busy  out  1  sweep in progress
sweep_done  out  1  one-cycle pulse on sweep completion
overrun  out  1  one-cycle pulse, tick_start while busy
spike_valid  out  1  spike event pending
spike_id  out  ID_W  index of spiking neuron
spike_ready  in  1  downstream accepts event

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk, rst_n).
- Reset values:
  - All V = VRESET; all B = 0.
  - busy, sweep_done, overrun, spike_valid = 0; spike_id = 0; mon_v = 0.
  - FSM in IDLE.
  - Reset mid-sweep or mid-EMIT aborts immediately; the pending spike is lost.
- FSM: IDLE -> READ -> CALC -> WRITE -> (EMIT) -> READ of next index, or DONE -> IDLE.
  - IDLE: tick_start=1 -> READ with idx=0; busy goes 1 next cycle.
  - READ: latch V[idx] and B[idx] into operand registers.
  - CALC: compute the candidate next V, registered.
  - WRITE: store the new V[idx].
    - If the neuron spiked -> EMIT.
    - Else if idx=NUM_NEURONS-1 -> DONE.
    - Else idx+1 -> READ.
  - EMIT: spike_valid=1, spike_id=idx, both stable until spike_ready. On valid&&ready, leave EMIT in that cycle (to DONE if last index, else READ idx+1). No other progress while stalled.
  - DONE: sweep_done=1 for one cycle, busy=0 from the next cycle, -> IDLE.
- Timing: a non-spiking neuron takes 3 cycles; a spiking neuron takes 4 cycles plus ready stall cycles. With no spikes, sweep_done is asserted 3*NUM_NEURONS+1 cycles after tick_start.
- Update arithmetic (signed, operands latched in READ):
  - If V >= VPEAK (signed compare): new V = VRESET and the neuron spikes. No other arithmetic.
  - Else: new V = sat8(V + (V>>>3)*(V>>>3)*(B>>>2)).
    - >>> is arithmetic shift, i.e. floor division.
    - Intermediates are at least 16-bit signed.
    - sat8 clamps to [-128, 127].
  - Spiking is decided on the V read, not on the computed value. A V that crosses VPEAK spikes on the next sweep.
- tick_start while busy is ignored; overrun pulses 1 cycle. tick_start in the same cycle as sweep_done counts as an overrun.
- Config writes:
  - cfg_we is accepted every cycle, including mid-sweep.
  - A write lands the cycle after it is presented.
  - A write in the same cycle as READ of the same index is not seen by that READ; it is used next sweep.
- mon_v = V[mon_addr] as of the previous cycle, registered. It reflects WRITE updates one cycle after the store.

Test Plan:
- Reset, then NUM_NEURONS=8, all B=0, one tick -> all V stay -20 (floor(-20/8)=-3, B>>>2=0); sweep_done exactly 25 cycles after tick; no spike_valid.
- B[2]=40, tick -> mon_v(2)=70. Second tick with spike_ready=1 -> spike_valid with spike_id=2 for 1 cycle, V[2]=-20, sweep_done 26 cycles after tick.
- Same as the previous test but spike_ready=0 for 5 cycles -> spike_valid/spike_id held stable, sweep_done delayed by 5 cycles, no neuron after 2 updated until the handshake.
- B[5]=-40, two ticks -> V[5]=-110 then -128 (saturated, -110-1960).
- tick_start asserted at cycle 3 of a sweep -> overrun pulses once; sweep count unchanged; state matches a single sweep.
- Assert rst_n while spike_valid=1 mid-sweep -> all outputs 0 asynchronously, mon_v(any) reads -20 after release, next tick runs a clean sweep.
